// File: rtl/is_pkg.sv
// Shared types for the score-point/interval blocks: one-hot point state and default time width.
package is_pkg;

  localparam int unsigned IS_WIDTH = 32;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_WAIT    = 5'b00010,
    ST_FIRED   = 5'b00100,
    ST_SKIPPED = 5'b01000,
    ST_KILLED  = 5'b10000
  } point_state_t;

  function automatic logic is_terminal(point_state_t s);
    return (s == ST_FIRED) || (s == ST_SKIPPED) || (s == ST_KILLED);
  endfunction

endpackage

// File: rtl/event_point_if.sv
// Bundle of score-side inputs and point outputs for one event_point.
interface event_point_if
  import is_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int WIDTH = IS_WIDTH
);

  logic             enable;
  logic             trigger;
  logic             condition;
  logic             kill_req;
  logic [N_IN-1:0]  in_finished;
  logic [N_IN-1:0]  in_skip;
  logic [N_IN-1:0]  in_kill;
  logic [WIDTH-1:0] global_clock;

  logic             start;
  logic             skip_p;
  logic             kill_p;
  logic [WIDTH-1:0] start_time;
  logic             done;

  modport master (
    output enable, trigger, condition, kill_req,
    output in_finished, in_skip, in_kill, global_clock,
    input  start, skip_p, kill_p, start_time, done
  );

  modport slave (
    input  enable, trigger, condition, kill_req,
    input  in_finished, in_skip, in_kill, global_clock,
    output start, skip_p, kill_p, start_time, done
  );

endinterface

// File: rtl/point_input_tracker.sv
// Sticky finished/skip flags for one incoming interval; finished wins a same-cycle tie.
module point_input_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic i_track,
  input  logic i_fin,
  input  logic i_skp,
  output logic o_resolved,
  output logic o_any_fin
);

  logic r_fin;
  logic r_skp;
  logic w_open;
  logic w_fin_now;
  logic w_skp_now;

  // Once resolved, later pulses on this input are ignored.
  assign w_open    = ~(r_fin | r_skp);
  assign w_fin_now = w_open & i_fin;
  assign w_skp_now = w_open & i_skp & ~i_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fin <= 1'b0;
      r_skp <= 1'b0;
    end else if (i_track) begin
      if (w_fin_now) r_fin <= 1'b1;
      if (w_skp_now) r_skp <= 1'b1;
    end
  end

  assign o_resolved = r_fin | r_skp | w_fin_now | w_skp_now;
  assign o_any_fin  = r_fin | w_fin_now;

endmodule

// File: rtl/event_point.sv
// Score event point: waits for all incoming intervals (or a root trigger), then fires, skips or is killed.
// state   | meaning
// IDLE    | score not yet running
// WAIT    | collecting incoming interval results
// FIRED   | point started downstream (terminal)
// SKIPPED | skip propagated downstream (terminal)
// KILLED  | kill propagated downstream (terminal)
module event_point
  import is_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int WIDTH   = IS_WIDTH,
  parameter bit IS_ROOT = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  event_point_if.slave bus
);

  point_state_t     r_state;
  point_state_t     w_state_nxt;
  logic             r_start;
  logic [WIDTH-1:0] r_start_time;
  logic [N_IN-1:0]  w_resolved;
  logic [N_IN-1:0]  w_any_fin;
  logic             w_track;
  logic             w_kill;
  logic             w_fire;

  assign w_track = (r_state == ST_WAIT) && (IS_ROOT == 1'b0);

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_trk
    point_input_tracker u_trk (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_track    (w_track),
      .i_fin      (bus.in_finished[gi]),
      .i_skp      (bus.in_skip[gi]),
      .o_resolved (w_resolved[gi]),
      .o_any_fin  (w_any_fin[gi])
    );
  end

  assign w_kill = bus.kill_req | (|bus.in_kill);

  // Kill acts even while enable is low; only resolution/firing is frozen.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.kill_req)    w_state_nxt = ST_KILLED;
        else if (bus.enable) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_kill) begin
          w_state_nxt = ST_KILLED;
        end else if (bus.enable) begin
          if (IS_ROOT) begin
            if (bus.trigger) w_state_nxt = ST_FIRED;
          end else if (&w_resolved) begin
            w_state_nxt = ((|w_any_fin) && bus.condition) ? ST_FIRED : ST_SKIPPED;
          end
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  assign w_fire = (r_state == ST_WAIT) && (w_state_nxt == ST_FIRED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_start      <= 1'b0;
      r_start_time <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_fire;
      if (w_fire) r_start_time <= bus.global_clock;
    end
  end

  assign bus.start      = r_start;
  assign bus.start_time = r_start_time;
  assign bus.skip_p     = (r_state == ST_SKIPPED);
  assign bus.kill_p     = (r_state == ST_KILLED);
  assign bus.done       = is_terminal(r_state);

endmodule

// File: tb/tb_event_point.sv
// Bench for event_point: a normal and a root point share stimulus, checked each cycle against a behavioural model.
module tb_event_point;

  localparam int N = 2;
  localparam int W = 32;
  localparam int P_IDLE = 0, P_WAIT = 1, P_FIRED = 2, P_SKIP = 3, P_KILL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         enable, trigger, condition, kill_req;
  logic [N-1:0] fin_p, skp_p, kil_p;
  logic [W-1:0] gclk;

  event_point_if #(.N_IN(N), .WIDTH(W)) bus_a ();
  event_point_if #(.N_IN(N), .WIDTH(W)) bus_r ();

  assign bus_a.enable = enable;        assign bus_r.enable = enable;
  assign bus_a.trigger = trigger;      assign bus_r.trigger = trigger;
  assign bus_a.condition = condition;  assign bus_r.condition = condition;
  assign bus_a.kill_req = kill_req;    assign bus_r.kill_req = kill_req;
  assign bus_a.in_finished = fin_p;    assign bus_r.in_finished = fin_p;
  assign bus_a.in_skip = skp_p;        assign bus_r.in_skip = skp_p;
  assign bus_a.in_kill = kil_p;        assign bus_r.in_kill = kil_p;
  assign bus_a.global_clock = gclk;    assign bus_r.global_clock = gclk;

  event_point #(.N_IN(N), .WIDTH(W), .IS_ROOT(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  event_point #(.N_IN(N), .WIDTH(W), .IS_ROOT(1'b1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r.slave));

  int n_chk = 0;
  int n_err = 0;

  // Model: index 0 = normal point, 1 = root point.
  int       m_ph   [2];
  bit       m_fin  [2][N];
  bit       m_skp  [2][N];
  bit       m_start[2];
  logic [W-1:0] m_time[2];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ph[m] = P_IDLE;
      m_start[m] = 1'b0;
      m_time[m] = '0;
      for (int i = 0; i < N; i++) begin
        m_fin[m][i] = 1'b0;
        m_skp[m][i] = 1'b0;
      end
    end
  endtask

  task automatic model_step(int m, bit root);
    int ph;
    bit all_res, any_fin, fire;
    ph = m_ph[m];
    fire = 1'b0;
    if (ph == P_IDLE) begin
      if (kill_req) ph = P_KILL;
      else if (enable) ph = P_WAIT;
    end else if (ph == P_WAIT) begin
      all_res = 1'b1;
      any_fin = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!root && !m_fin[m][i] && !m_skp[m][i]) begin
          if (fin_p[i]) m_fin[m][i] = 1'b1;
          else if (skp_p[i]) m_skp[m][i] = 1'b1;
        end
        if (!m_fin[m][i] && !m_skp[m][i]) all_res = 1'b0;
        if (m_fin[m][i]) any_fin = 1'b1;
      end
      if (kill_req || (|kil_p)) ph = P_KILL;
      else if (enable) begin
        if (root) begin
          if (trigger) ph = P_FIRED;
        end else if (all_res) begin
          ph = (any_fin && condition) ? P_FIRED : P_SKIP;
        end
      end
      if (ph == P_FIRED) begin
        fire = 1'b1;
        m_time[m] = gclk;
      end
    end
    m_start[m] = fire;
    m_ph[m] = ph;
  endtask

  task automatic compare_one(string tag, int m, logic st, logic sk, logic kl, logic dn, logic [W-1:0] tm);
    check({tag, ".start"},      st, m_start[m]);
    check({tag, ".skip_p"},     sk, m_ph[m] == P_SKIP);
    check({tag, ".kill_p"},     kl, m_ph[m] == P_KILL);
    check({tag, ".done"},       dn, m_ph[m] >= P_FIRED);
    check({tag, ".start_time"}, tm, m_time[m]);
    check({tag, ".exclusive"},  (32'(st) + 32'(sk) + 32'(kl)) <= 1, 1'b1);
  endtask

  task automatic compare();
    compare_one("a", 0, bus_a.start, bus_a.skip_p, bus_a.kill_p, bus_a.done, bus_a.start_time);
    compare_one("r", 1, bus_r.start, bus_r.skip_p, bus_r.kill_p, bus_r.done, bus_r.start_time);
  endtask

  task automatic clear_pulses();
    trigger = 1'b0;
    fin_p = '0;
    skp_p = '0;
    kil_p = '0;
  endtask

  // Called just after a negedge with inputs set; returns just after the next negedge.
  task automatic step();
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    @(negedge clk);
    compare();
    clear_pulses();
    gclk = gclk + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    clear_pulses();
    enable = 1'b0;
    kill_req = 1'b0;
    #1;
    compare();
    @(posedge clk);
    @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0; condition = 1'b1; kill_req = 1'b0;
    gclk = '0;
    clear_pulses();
    model_reset();
    @(negedge clk);

    // Both inputs finished, condition high: start one cycle after the last pulse.
    do_reset();
    enable = 1'b1; condition = 1'b1;
    step(); step(); step();
    fin_p = 2'b01; step();
    step(); step(); step();
    fin_p = 2'b10; gclk = 100; step();
    check("dir_fire.start", bus_a.start, 1'b1);
    check("dir_fire.start_time", bus_a.start_time, 100);
    step();
    check("dir_fire.start_once", bus_a.start, 1'b0);
    check("dir_fire.done", bus_a.done, 1'b1);

    // Both inputs skipped.
    do_reset();
    enable = 1'b1;
    step();
    skp_p = 2'b01; step();
    skp_p = 2'b10; step();
    check("dir_skip.skip_p", bus_a.skip_p, 1'b1);
    check("dir_skip.start", bus_a.start, 1'b0);
    step(); step();
    check("dir_skip.hold", bus_a.skip_p, 1'b1);

    // Kill wins over the resolving finish in the same cycle.
    do_reset();
    enable = 1'b1;
    step();
    fin_p = 2'b01; step();
    step(); step();
    fin_p = 2'b10; kil_p = 2'b01; step();
    check("dir_kill.kill_p", bus_a.kill_p, 1'b1);
    check("dir_kill.start", bus_a.start, 1'b0);

    // Condition low on the resolving cycle skips.
    do_reset();
    enable = 1'b1; condition = 1'b1;
    step();
    fin_p = 2'b01; step();
    condition = 1'b0; fin_p = 2'b10; step();
    check("dir_cond0.skip_p", bus_a.skip_p, 1'b1);
    check("dir_cond0.start", bus_a.start, 1'b0);
    condition = 1'b1;

    // Same-cycle finish and skip on one input counts as finished.
    do_reset();
    enable = 1'b1;
    step();
    fin_p = 2'b11; skp_p = 2'b01; step();
    check("dir_tie.start", bus_a.start, 1'b1);

    // Root: trigger fires, later triggers ignored.
    do_reset();
    enable = 1'b1;
    step(); step();
    gclk = 32'h0000_FFFF; trigger = 1'b1; step();
    check("dir_root.start", bus_r.start, 1'b1);
    check("dir_root.start_time", bus_r.start_time, 32'h0000_FFFF);
    gclk = 5; trigger = 1'b1; step();
    check("dir_root.retrig", bus_r.start, 1'b0);
    check("dir_root.time_hold", bus_r.start_time, 32'h0000_FFFF);

    // Reset discards an accumulated flag.
    do_reset();
    enable = 1'b1;
    step();
    fin_p = 2'b01; step();
    do_reset();
    enable = 1'b1;
    step();
    fin_p = 2'b10; step();
    step(); step();
    check("dir_rst.no_done", bus_a.done, 1'b0);
    check("dir_rst.no_start", bus_a.start, 1'b0);

    // Enable low in WAIT freezes resolution but flags still accumulate.
    do_reset();
    enable = 1'b1;
    step();
    enable = 1'b0; fin_p = 2'b11; step();
    step();
    check("dir_frz.no_done", bus_a.done, 1'b0);
    enable = 1'b1; step();
    check("dir_frz.start", bus_a.start, 1'b1);

    // kill_req in IDLE kills regardless of enable.
    do_reset();
    kill_req = 1'b1; step();
    kill_req = 1'b0;
    check("dir_idlekill.kill_p", bus_a.kill_p, 1'b1);

    // Randomized episodes.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        enable    = ($urandom_range(0, 9) < 8);
        trigger   = ($urandom_range(0, 9) == 0);
        condition = ($urandom_range(0, 3) != 0);
        kill_req  = ($urandom_range(0, 39) == 0);
        for (int i = 0; i < N; i++) begin
          fin_p[i] = ($urandom_range(0, 7) == 0);
          skp_p[i] = ($urandom_range(0, 9) == 0);
          kil_p[i] = ($urandom_range(0, 49) == 0);
        end
        if ($urandom_range(0, 3) == 0) gclk = $urandom;
        step();
      end
      kill_req = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/event_point.md
EVENT_POINT -- requirements
Module: event_point

Interface
REQ-001 Parameter N_IN, default 2, number of incoming intervals (1..8).
REQ-002 Parameter WIDTH, default 32, width of global_clock and start_time.
REQ-003 Parameter IS_ROOT, default 0; 1 = point fires on trigger, ignoring incoming intervals.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  score running; no resolution or firing while low.
REQ-007 trigger  in  1  root start pulse (used only when IS_ROOT=1).
REQ-008 condition  in  1  point condition, sampled on the resolution cycle.
REQ-009 kill_req  in  1  external kill request (level).
REQ-010 in_finished  in  N_IN  per-input one-cycle pulse from upstream interval "finished".
REQ-011 in_skip  in  N_IN  per-input one-cycle pulse from upstream interval "skip".
REQ-012 in_kill  in  N_IN  per-input one-cycle pulse from upstream interval "kill".
REQ-013 global_clock  in  WIDTH  free-running score time.
REQ-014 start  out  1  one-cycle pulse, starts downstream intervals.
REQ-015 skip_p  out  1  level, skip propagation to downstream intervals.
REQ-016 kill_p  out  1  level, kill propagation to downstream intervals.
REQ-017 start_time  out  WIDTH  global_clock value captured when the point fires.
REQ-018 done  out  1  level, point in any terminal state.

Function
REQ-019 FSM states: IDLE, WAIT, FIRED, SKIPPED, KILLED; FIRED/SKIPPED/KILLED are terminal and absorbing until reset.
REQ-020 IDLE -> WAIT when enable=1; IDLE -> KILLED on kill_req regardless of enable.
REQ-021 WAIT: per-input sticky flags fin[i], skp[i]; set on the respective pulse, never cleared before reset; a repeat pulse on a resolved input is ignored.
REQ-022 Same-cycle in_finished[i] and in_skip[i]: fin[i] is set, skp[i] is not.
REQ-023 Input i is resolved when fin[i] or skp[i]; resolution uses registered flags OR'd with current-cycle pulses.
REQ-024 All inputs resolved, any fin, condition=1 -> FIRED; otherwise, all inputs resolved -> SKIPPED.
REQ-025 IS_ROOT=1: WAIT -> FIRED on trigger; the in_* inputs are ignored except in_kill.
REQ-026 Any in_kill bit or kill_req in WAIT -> KILLED; kill has priority over resolution in the same cycle.
REQ-027 enable low in WAIT freezes the FSM transition; flags still accumulate.
REQ-028 start is registered, high exactly the one cycle after the resolving cycle, i.e. the first cycle in FIRED; latency 1 from the last resolving pulse.
REQ-029 start_time latches global_clock of the resolving cycle, held thereafter; WIDTH-bit unsigned, no arithmetic.
REQ-030 skip_p = (state==SKIPPED); kill_p = (state==KILLED); done = terminal state; all outputs registered or decoded from registered state only, no input-to-output combinational path.
REQ-031 start, skip_p and kill_p are mutually exclusive at all times.

Reset
REQ-032 rst_n low asynchronously forces IDLE and clears all flags; start=0, skip_p=0, kill_p=0, done=0, start_time=0.
REQ-033 Reset mid-WAIT or in a terminal state discards all accumulated flags; the first clock edge after deassertion sees IDLE.

Structure
REQ-034 Shared package is_pkg holds point_state_t (one-hot 5-bit enum) and the default WIDTH constant, shared with the interval blocks.
REQ-035 One sub-module point_input_tracker (per-input sticky fin/skp flags with the REQ-022 priority), instantiated N_IN times via generate.

Verification
REQ-036 N_IN=2, enable=1, condition=1: in_finished[0] @t=5, in_finished[1] @t=9, global_clock=100 @t=9 -> start high only @t=10, start_time=100, done=1.
REQ-037 N_IN=2: in_skip[0] @t=5, in_skip[1] @t=6 -> skip_p high from t=7 onward, start never asserted.
REQ-038 N_IN=2: in_finished[0] @t=5, in_finished[1] plus in_kill[0] @t=8 -> kill_p high from t=9, no start.
REQ-039 N_IN=2, condition=0 on the resolving cycle: both finished -> SKIPPED, skip_p=1, start=0.
REQ-040 IS_ROOT=1: trigger @t=3 with global_clock=0x0000_FFFF -> start @t=4, start_time=0x0000_FFFF; further trigger pulses are ignored.
REQ-041 rst_n asserted @t=7 after in_finished[0] @t=5; reset released, then in_finished[1] alone -> no start (flag 0 was cleared).
